// File: rtl/fp_pkg.sv
// Shared constants and types for the floating-point post-add normalization stage.
// Word layout: {signed exponent, signed two's-complement mantissa}.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 24;
  localparam int WORD_W = EXP_W + MANT_W;

  localparam logic signed [EXP_W-1:0] EXP_MIN      = 8'sh80;
  localparam logic signed [EXP_W-1:0] EXP_MAX      = 8'sh7F;
  // Lowest exponent from which a 4-bit shift cannot step past EXP_MIN.
  localparam logic signed [EXP_W-1:0] EXP_FAST_MIN = 8'sh84;

  localparam logic [MANT_W-1:0] MANT_POS_MAX = 24'h7FFFFF;
  localparam logic [MANT_W-1:0] MANT_NEG_MAX = 24'h800000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fp_norm_detect.sv
// Combinational mantissa classifier: zero, already normalized, and safe-to-shift-by-4.
module fp_norm_detect
  import fp_pkg::*;
(
  input  logic [MANT_W-1:0] mant_i,
  output logic              is_zero_o,
  output logic              is_norm_o,
  output logic              can_shift4_o
);

  assign is_zero_o    = (mant_i == {MANT_W{1'b0}});
  assign is_norm_o    = (mant_i[MANT_W-1] != mant_i[MANT_W-2]);
  // Five equal top bits means at least four redundant sign bits to drop.
  assign can_shift4_o = !is_zero_o && (mant_i[MANT_W-1:MANT_W-5] == {5{mant_i[MANT_W-1]}});

endmodule

// File: rtl/fp_normalize.sv
// Iterative post-add normalizer with valid/ready handshakes on both sides.
// Define FP_NORM_FAST_SHIFT_EN to allow 4-bit shift steps (same results, lower latency).
module fp_normalize
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  input  logic        in_ovf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        out_zero,
  output logic        out_exp_ovf,
  output logic        out_exp_unf
);

  state_e                   state_q, state_d;
  logic [MANT_W-1:0]        mant_q, mant_d;
  logic signed [EXP_W-1:0]  exp_q, exp_d;
  logic                     sat_q, sat_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic [WORD_W-1:0]        out_word_q, out_word_d;
  logic                     out_zero_q, out_zero_d;
  logic                     out_exp_ovf_q, out_exp_ovf_d;
  logic                     out_exp_unf_q, out_exp_unf_d;

  logic                     is_zero_s, is_norm_s, can_shift4_s, fast_step_s;
  logic signed [EXP_W-1:0]  in_exp_s;
  logic [MANT_W-1:0]        in_mant_s;

  assign in_exp_s  = $signed(in_word[WORD_W-1:MANT_W]);
  assign in_mant_s = in_word[MANT_W-1:0];

  fp_norm_detect u_detect (
    .mant_i       (mant_q),
    .is_zero_o    (is_zero_s),
    .is_norm_o    (is_norm_s),
    .can_shift4_o (can_shift4_s)
  );

`ifdef FP_NORM_FAST_SHIFT_EN
  assign fast_step_s = can_shift4_s && (exp_q >= EXP_FAST_MIN);
`else
  // Detector is shared by both builds; the wide step is tied off here.
  assign fast_step_s = can_shift4_s & 1'b0;
`endif

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d       = state_q;
    mant_d        = mant_q;
    exp_d         = exp_q;
    sat_d         = sat_q;
    in_ready_d    = in_ready_q;
    out_valid_d   = out_valid_q;
    out_word_d    = out_word_q;
    out_zero_d    = out_zero_q;
    out_exp_ovf_d = out_exp_ovf_q;
    out_exp_unf_d = out_exp_unf_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d    = NORM;
          in_ready_d = 1'b0;
          if (!in_ovf) begin
            mant_d = in_mant_s;
            exp_d  = in_exp_s;
            sat_d  = 1'b0;
          end else if (in_exp_s != EXP_MAX) begin
            // Restore the lost sign bit; the result is already normalized.
            mant_d = {~in_mant_s[MANT_W-1], in_mant_s[MANT_W-1:1]};
            exp_d  = in_exp_s + 8'sd1;
            sat_d  = 1'b0;
          end else begin
            mant_d = in_mant_s[MANT_W-1] ? MANT_POS_MAX : MANT_NEG_MAX;
            exp_d  = EXP_MAX;
            sat_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      NORM: begin
        if (is_zero_s) begin
          state_d       = DONE;
          out_valid_d   = 1'b1;
          out_word_d    = {WORD_W{1'b0}};
          out_zero_d    = 1'b1;
          out_exp_ovf_d = 1'b0;
          out_exp_unf_d = 1'b0;
        end else if (is_norm_s || (exp_q == EXP_MIN)) begin
          state_d       = DONE;
          out_valid_d   = 1'b1;
          out_word_d    = {exp_q, mant_q};
          out_zero_d    = 1'b0;
          out_exp_ovf_d = sat_q;
          out_exp_unf_d = !is_norm_s;
        end else if (fast_step_s) begin
          mant_d = {mant_q[MANT_W-5:0], 4'b0000};
          exp_d  = exp_q - 8'sd4;
        end else begin
          mant_d = {mant_q[MANT_W-2:0], 1'b0};
          exp_d  = exp_q - 8'sd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      mant_q        <= {MANT_W{1'b0}};
      exp_q         <= 8'sd0;
      sat_q         <= 1'b0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_word_q    <= {WORD_W{1'b0}};
      out_zero_q    <= 1'b0;
      out_exp_ovf_q <= 1'b0;
      out_exp_unf_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mant_q        <= mant_d;
      exp_q         <= exp_d;
      sat_q         <= sat_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_word_q    <= out_word_d;
      out_zero_q    <= out_zero_d;
      out_exp_ovf_q <= out_exp_ovf_d;
      out_exp_unf_q <= out_exp_unf_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_word    = out_word_q;
  assign out_zero    = out_zero_q;
  assign out_exp_ovf = out_exp_ovf_q;
  assign out_exp_unf = out_exp_unf_q;

endmodule
